uart_rx_core: RTL and testbench
===============================

# uart_rx_core

Serial-to-parallel receive engine for the UART-Rx path; consumes the 16x-oversampling `baud_clk` from the Rx baud generator and the raw serial line. It detects start bits, samples each bit at mid-bit, and checks parity and stop bits. It delivers one received byte per frame with a single-cycle valid strobe and error flags.

## Interface
- DATA_BITS, 8, number of data bits per frame, sent LSB first.
- clock  input  1  system main clock; all logic on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- baud_clk  input  1  16x-oversampling clock from the baud generator, generated synchronously in `clock` domain. Each rising edge is one oversample tick.
- data_tx  input  1  serial line, idle high, asynchronous to `clock`.
- parity_type  input  2  00 none, 01 odd, 10 even, 11 none.
- stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
- data_out  output  DATA_BITS  last received byte; held until the next frame completes.
- data_valid  output  1  one-`clock` pulse when `data_out` and the error flags update.
- parity_error  output  1  parity mismatch on the last frame; updates with `data_valid`.
- frame_error  output  1  any stop bit sampled low on the last frame; updates with `data_valid`.
- busy  output  1  high whenever the state is not IDLE.

## Operation
- `data_tx` passes through a 2-flop synchronizer (both flops reset to 1). "line" below is the synchronizer output.
- Tick generation:
  - `baud_d` registers `baud_clk` (reset 0).
  - `tick = baud_clk & ~baud_d`, so there is at most one tick per clock.
  - No synchronizer on `baud_clk`.
- 4-bit `tick_cnt` and a bit counter (width ceil(log2(DATA_BITS+1))) advance only on tick clocks.
- On leaving IDLE, `parity_type` and `stop_bits` are latched. Changes mid-frame are ignored.
- States:
  - IDLE: on tick with line = 0 → START, `tick_cnt` = 0.
  - START: on each tick `tick_cnt`++. On the tick where `tick_cnt` == 7 (mid start bit):
    - line = 0 → DATA, with `tick_cnt` = 0 and bit count = 0.
    - line = 1 → IDLE (false start; no outputs change).
  - DATA: on each tick `tick_cnt`++. On the tick where `tick_cnt` == 15:
    - Shift line into the MSB of the shift register (shift right), `tick_cnt` = 0, bit count++.
    - After the DATA_BITS-th bit → PARITY if the latched parity is 01/10, else STOP1.
  - PARITY: at `tick_cnt` == 15, sample the parity bit.
    - Odd: error if XOR(data, p) != 1.
    - Even: error if XOR(data, p) != 0.
    - Then → STOP1.
  - STOP1: at `tick_cnt` == 15, sample; a low sample sets the pending frame error. Then → STOP2 if two stop bits, else DONE.
  - STOP2: same sampling as STOP1, then → DONE.
  - DONE: single clock, no tick needed.
    - `data_out` ← shift register; `parity_error`/`frame_error` ← pending flags; `data_valid` = 1.
    - Pending flags are cleared. → IDLE.
- A frame error does not discard data; the byte is still delivered with `frame_error` = 1.
- Parity bit is not included in `data_out`.

## Timing
- Reset values: `data_out` = 0, `data_valid` = 0, `parity_error` = 0, `frame_error` = 0, `busy` = 0, state IDLE, counters 0, shift register 0.
- Reset mid-frame aborts immediately and asynchronously; no `data_valid` for the aborted frame.
- Tick numbering: tick 0 is the first tick at which line = 0 is seen in IDLE.
  - Start validated at tick 7.
  - Data bit k (k = 0..DATA_BITS-1) sampled at tick 7+16(k+1).
  - Parity, then each stop bit, follow at successive +16 tick intervals.
- Latency: `data_valid` is high exactly one clock after the clock that processes the final stop-bit tick. It is high for exactly one clock.
- `busy` rises the clock after the start tick and falls the clock after DONE.
- Back-to-back frames: IDLE is re-entered mid final stop bit. A start edge arriving any time after that is accepted, so there is no dead time.
- Line sample delay through the synchronizer is 2 clocks, which is negligible against a bit time of 16 ticks.
- Error flags and `data_out` are static between `data_valid` pulses.

## Test plan
- **Valid frame, no parity, 1 stop:** bench `baud_clk` rising edge every 4 clocks, 16 ticks/bit, parity 00. Send 0xA5 → one `data_valid` pulse, `data_out` = 0xA5, both errors 0, `busy` low afterwards.
- **Even parity:** parity 10, send 0x3C with parity bit 0 → `parity_error` = 0. Resend 0x3C with parity bit 1 → `parity_error` = 1, `data_out` = 0x3C.
- **Odd parity, two stop bits:** parity 01, `stop_bits` = 1, send 0x01 with parity 0 and stops 1,1 → no errors. Repeat with second stop bit 0 → `frame_error` = 1, `data_out` = 0x01.
- **False start:** line low for 4 ticks then high → no `data_valid`; `busy` falls 1 clock after the tick-7 sample; next frame 0x5A is received correctly.
- **Reset mid-frame:** assert `reset_n` low during data bit 3 → all outputs 0 immediately. Release and send 0x5A → `data_out` = 0x5A, single `data_valid`.
- **Back-to-back and config change:** send 0xFF immediately followed by 0x00, and toggle `parity_type` mid-frame → two `data_valid` pulses in order, data 0xFF then 0x00, and the mid-frame parity change has no effect on the frame in progress.

Source files
------------

// File: rtl/uart_rx_core.sv
// UART receive engine: samples the serial line at 16x oversampling, checks parity and stop bits,
// and delivers each byte with a one-clock valid strobe and error flags.
module uart_rx_core #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 baud_clk,
  input  logic                 data_tx,
  input  logic [1:0]           parity_type,
  input  logic                 stop_bits,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 busy,
  output logic [2:0]           dbg_state
);

  localparam int BCW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_DONE
  } state_t;

  state_t                 r_state, r_next;
  logic [1:0]             r_sync;
  logic                   r_baud_d;
  logic [3:0]             r_tick_cnt;
  logic [BCW-1:0]         r_bit_cnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic [1:0]             r_par_cfg;
  logic                   r_two_stop;
  logic                   r_par_pend;
  logic                   r_frm_pend;
  logic [DATA_BITS-1:0]   r_data_out;
  logic                   r_parity_error;
  logic                   r_frame_error;

  logic w_line, w_tick, w_mid, w_start_mid, w_last_bit, w_par_en, w_enter_done;

  assign w_line      = r_sync[1];
  assign w_tick      = baud_clk & ~r_baud_d;
  assign w_mid       = w_tick && (r_tick_cnt == 4'd15);
  // The start tick itself leaves the counter at 0, so tick 7 sees a pre-increment value of 6.
  assign w_start_mid = w_tick && (r_tick_cnt == 4'd6);
  assign w_last_bit  = (r_bit_cnt == BCW'(DATA_BITS - 1));
  assign w_par_en    = (r_par_cfg == 2'b01) || (r_par_cfg == 2'b10);
  assign w_enter_done = (r_state != S_DONE) && (r_next == S_DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      S_IDLE:   if (w_tick && !w_line) r_next = S_START;
      S_START:  if (w_start_mid) r_next = w_line ? S_IDLE : S_DATA;
      S_DATA:   if (w_mid && w_last_bit) r_next = w_par_en ? S_PARITY : S_STOP1;
      S_PARITY: if (w_mid) r_next = S_STOP1;
      S_STOP1:  if (w_mid) r_next = r_two_stop ? S_STOP2 : S_DONE;
      S_STOP2:  if (w_mid) r_next = S_DONE;
      S_DONE:   r_next = S_IDLE;
      default:  r_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync         <= 2'b11;
      r_baud_d       <= 1'b0;
      r_tick_cnt     <= 4'd0;
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_par_cfg      <= 2'b00;
      r_two_stop     <= 1'b0;
      r_par_pend     <= 1'b0;
      r_frm_pend     <= 1'b0;
      r_data_out     <= '0;
      r_parity_error <= 1'b0;
      r_frame_error  <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], data_tx};
      r_baud_d <= baud_clk;
      if (w_tick) begin
        case (r_state)
          S_IDLE: if (!w_line) begin
            r_tick_cnt <= 4'd0;
            r_par_cfg  <= parity_type;
            r_two_stop <= stop_bits;
          end
          S_START: begin
            if (r_tick_cnt == 4'd6) begin
              r_tick_cnt <= 4'd0;
              r_bit_cnt  <= '0;
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
          S_DATA: begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
            if (r_tick_cnt == 4'd15) begin
              r_shift   <= {w_line, r_shift[DATA_BITS-1:1]};
              r_bit_cnt <= r_bit_cnt + BCW'(1);
            end
          end
          S_PARITY: begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
            // cfg[0] is 1 for odd parity, where the XOR over data and parity must be 1.
            if (r_tick_cnt == 4'd15) r_par_pend <= ^r_shift ^ w_line ^ r_par_cfg[0];
          end
          S_STOP1, S_STOP2: begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
            if ((r_tick_cnt == 4'd15) && !w_line) r_frm_pend <= 1'b1;
          end
          default: ;
        endcase
      end
      // Results are loaded as DONE is entered so they are already stable while data_valid is high.
      if (w_enter_done) begin
        r_data_out     <= r_shift;
        r_parity_error <= r_par_pend;
        r_frame_error  <= r_frm_pend | ~w_line;
        r_par_pend     <= 1'b0;
        r_frm_pend     <= 1'b0;
      end
    end
  end

  assign data_out     = r_data_out;
  assign parity_error = r_parity_error;
  assign frame_error  = r_frame_error;
  assign data_valid   = (r_state == S_DONE);
  assign busy         = (r_state != S_IDLE);
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: 4 clocks per oversample tick, 64 clocks per bit.
module tb_uart_rx_core;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       baud_clk = 1'b0;
  logic       data_tx = 1'b1;
  logic [1:0] parity_type = 2'b00;
  logic       stop_bits = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, parity_error, frame_error, busy;
  logic [2:0] dbg_state;

  int checks = 0;
  int failures = 0;
  int n_valid = 0;
  int cyc = 0;
  logic [1:0] baud_cnt = 2'd0;
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];

  uart_rx_core #(.DATA_BITS(8)) dut (
    .clock(clock), .reset_n(reset_n), .baud_clk(baud_clk), .data_tx(data_tx),
    .parity_type(parity_type), .stop_bits(stop_bits), .data_out(data_out),
    .data_valid(data_valid), .parity_error(parity_error), .frame_error(frame_error),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock and baud generation: baud_clk is high one clock in every four.
  always #5 clock = ~clock;
  always @(posedge clock) begin
    baud_cnt <= baud_cnt + 2'd1;
    baud_clk <= (baud_cnt == 2'd3);
  end

  // Monitor: every valid clock is captured as {parity_error, frame_error, data_out}.
  always @(negedge clock) begin
    cyc = cyc + 1;
    if (data_valid) begin
      n_valid = n_valid + 1;
      got_q.push_back({parity_error, frame_error, data_out});
    end
  end

  task automatic drive_bit(input logic b);
    data_tx = b;
    repeat (64) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                            input logic two, input logic s2);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (has_par) drive_bit(pbit);
    drive_bit(1'b1);
    if (two) begin
      if (s2) drive_bit(1'b1);
      else begin
        data_tx = 1'b0;
        repeat (48) @(negedge clock);
        data_tx = 1'b1;
        repeat (16) @(negedge clock);
      end
    end
  endtask

  task automatic wait_frames(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (got_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    repeat (5) @(negedge clock);
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_data_valid got=%b exp=0", data_valid); end
    checks++; if (parity_error !== 1'b0) begin failures++; $display("FAIL reset_parity_error got=%b exp=0", parity_error); end
    checks++; if (frame_error !== 1'b0) begin failures++; $display("FAIL reset_frame_error got=%b exp=0", frame_error); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (dbg_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
  endtask

  task automatic test_no_parity;
    bit ok;
    int v0;
    logic [9:0] got, e;
    parity_type = 2'b00; stop_bits = 1'b0; v0 = n_valid;
    exp_q.push_back({2'b00, 8'hA5});
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_frames(1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL np_timeout got=none exp=frame"); void'(exp_q.pop_front()); end
    else begin
      got = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (got !== e) begin failures++; $display("FAIL np_a5 got=%h exp=%h", got, e); end
    end
    repeat (64) @(negedge clock);
    checks++; if (n_valid - v0 !== 1) begin failures++; $display("FAIL np_pulses got=%0d exp=1", n_valid - v0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL np_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_even_parity;
    bit ok;
    logic [9:0] got, e;
    parity_type = 2'b10; stop_bits = 1'b0;
    for (int k = 0; k < 2; k++) begin
      // 0x3C has four ones: parity bit 0 is correct, 1 is wrong.
      exp_q.push_back({(k == 1), 1'b0, 8'h3C});
      send_frame(8'h3C, 1'b1, (k == 1), 1'b0, 1'b1);
      wait_frames(1, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL even_timeout_%0d got=none exp=frame", k); void'(exp_q.pop_front()); end
      else begin
        got = got_q.pop_front(); e = exp_q.pop_front();
        checks++; if (got !== e) begin failures++; $display("FAIL even_%0d got=%h exp=%h", k, got, e); end
      end
      repeat (64) @(negedge clock);
    end
  endtask

  task automatic test_odd_two_stop;
    bit ok;
    logic [9:0] got, e;
    parity_type = 2'b01; stop_bits = 1'b1;
    for (int k = 0; k < 2; k++) begin
      // 0x01 has one one, so odd parity bit 0 is correct; second run drops the second stop bit.
      exp_q.push_back({1'b0, (k == 1), 8'h01});
      send_frame(8'h01, 1'b1, 1'b0, 1'b1, (k == 0));
      wait_frames(1, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL odd_timeout_%0d got=none exp=frame", k); void'(exp_q.pop_front()); end
      else begin
        got = got_q.pop_front(); e = exp_q.pop_front();
        checks++; if (got !== e) begin failures++; $display("FAIL odd_stop_%0d got=%h exp=%h", k, got, e); end
      end
      repeat (100) @(negedge clock);
    end
    stop_bits = 1'b0;
  endtask

  task automatic test_false_start;
    bit ok;
    int v0, rise, fall;
    logic [9:0] got, e;
    parity_type = 2'b00; stop_bits = 1'b0;
    repeat (100) @(negedge clock);
    got_q.delete();
    v0 = n_valid; rise = -1; fall = -1;
    data_tx = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (i == 15) data_tx = 1'b1;
      if (busy && rise < 0) rise = i;
      if (!busy && rise >= 0 && fall < 0) fall = i;
    end
    checks++; if (rise < 0) begin failures++; $display("FAIL fs_busy_rise got=none exp=rise"); end
    // busy spans tick 0 to tick 7: seven ticks of four clocks.
    checks++; if (fall - rise !== 28) begin failures++; $display("FAIL fs_busy_len got=%0d exp=28", fall - rise); end
    checks++; if (n_valid !== v0) begin failures++; $display("FAIL fs_no_valid got=%0d exp=%0d", n_valid, v0); end
    exp_q.push_back({2'b00, 8'h5A});
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_frames(1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL fs_timeout got=none exp=frame"); void'(exp_q.pop_front()); end
    else begin
      got = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (got !== e) begin failures++; $display("FAIL fs_next_5a got=%h exp=%h", got, e); end
    end
    repeat (64) @(negedge clock);
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    int v0;
    logic [9:0] got, e;
    logic [7:0] d;
    d = 8'h5A; v0 = n_valid;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    data_tx = d[3];
    repeat (32) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL rst_mid_data_out got=%h exp=00", data_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", data_valid); end
    checks++; if ({parity_error, frame_error} !== 2'b00) begin failures++; $display("FAIL rst_mid_flags got=%b exp=00", {parity_error, frame_error}); end
    data_tx = 1'b1;
    repeat (10) @(negedge clock);
    reset_n = 1'b1;
    repeat (100) @(negedge clock);
    checks++; if (n_valid !== v0) begin failures++; $display("FAIL rst_mid_no_valid got=%0d exp=%0d", n_valid, v0); end
    exp_q.push_back({2'b00, 8'h5A});
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_frames(1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rst_after_timeout got=none exp=frame"); void'(exp_q.pop_front()); end
    else begin
      got = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (got !== e) begin failures++; $display("FAIL rst_after_5a got=%h exp=%h", got, e); end
    end
    repeat (64) @(negedge clock);
    checks++; if (n_valid - v0 !== 1) begin failures++; $display("FAIL rst_after_pulses got=%0d exp=1", n_valid - v0); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int v0;
    logic [9:0] got, e;
    parity_type = 2'b00; stop_bits = 1'b0; v0 = n_valid;
    exp_q.push_back({2'b00, 8'hFF});
    exp_q.push_back({2'b00, 8'h00});
    // parity_type is even while each frame's data ends; both frames latched "none" at their start.
    fork
      begin
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      begin
        repeat (200) @(negedge clock); parity_type = 2'b10;
        repeat (425) @(negedge clock); parity_type = 2'b00;
        repeat (215) @(negedge clock); parity_type = 2'b10;
      end
    join
    parity_type = 2'b00;
    wait_frames(2, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_timeout got=%0d exp=2", got_q.size()); end
    for (int k = 0; k < 2; k++) begin
      if (got_q.size() > 0) begin
        got = got_q.pop_front(); e = exp_q.pop_front();
        checks++; if (got !== e) begin failures++; $display("FAIL b2b_frame_%0d got=%h exp=%h", k, got, e); end
      end
    end
    exp_q.delete();
    repeat (64) @(negedge clock);
    checks++; if (n_valid - v0 !== 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", n_valid - v0); end
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_even_parity();
    test_odd_two_stop();
    test_false_start();
    test_reset_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
